// File: rtl/output_seq_pkg.sv
// Shared encodings and default lengths for the output drive sequencer.
package output_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISMATCH = 2'd1;
  localparam logic [1:0] FLT_TIMEOUT  = 2'd2;

  localparam int unsigned SHORT_LEN   = 1;
  localparam int unsigned LONG_LEN    = 15;
  localparam int unsigned WDOG_LEN    = 64;
  localparam int unsigned ARM_MATCHES = 4;

endpackage

// File: rtl/output_drive_sequencer_pulse_phase_gen.sv
// Asymmetric switch pulse train; the high phase leads, starting on the
// first RUN cycle, and the phase counter wraps with no gap cycle.
module pulse_phase_gen #(
  parameter bit          POLARITY  = 1'b0,
  parameter int unsigned SHORT_LEN = output_seq_pkg::SHORT_LEN,
  parameter int unsigned LONG_LEN  = output_seq_pkg::LONG_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic runNow,
  input  logic runNext,
  output logic switchCtrl
);

  localparam int unsigned HIGH_LEN =
    POLARITY ? LONG_LEN : SHORT_LEN;
  localparam logic [5:0] HIGH = 6'(HIGH_LEN);
  localparam logic [5:0] LAST = 6'(SHORT_LEN + LONG_LEN - 1);

  logic [5:0] phase;
  logic [5:0] phaseNext;

  assign phaseNext = (phase == LAST) ? '0 : phase + 6'd1;

  always_ff @(posedge clk) begin
    if (rst || !runNext) begin
      phase      <= '0;
      switchCtrl <= 1'b0;
    end else if (!runNow) begin
      phase      <= '0;
      switchCtrl <= 1'b1;
    end else begin
      phase      <= phaseNext;
      switchCtrl <= (phaseNext < HIGH);
    end
  end

endmodule

// File: rtl/output_drive_sequencer.sv
// Per-channel relay/switch drive sequencer; outputs run only while
// compare results keep arriving and matching, otherwise fall static.
module output_drive_sequencer #(
  parameter bit          POLARITY    = 1'b0,
  parameter int unsigned SHORT_LEN   = output_seq_pkg::SHORT_LEN,
  parameter int unsigned LONG_LEN    = output_seq_pkg::LONG_LEN,
  parameter int unsigned ARM_MATCHES = output_seq_pkg::ARM_MATCHES,
  parameter int unsigned WDOG_LEN    = output_seq_pkg::WDOG_LEN
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_req,
  input  logic       cmp_valid,
  input  logic       cmp_match,
  input  logic       fault_clear,
  output logic       relay_ctrl,
  output logic       switch_ctrl,
  output logic       ready,
  output logic [1:0] state,
  output logic [1:0] fault_code
);
  import output_seq_pkg::*;

  localparam logic [7:0] WDOG_LAST = 8'(WDOG_LEN - 1);
  localparam logic [3:0] ARM_LAST  = 4'(ARM_MATCHES - 1);

  state_t     stateQ, stateD;
  logic [1:0] faultQ, faultD;
  logic [3:0] matchQ, matchD;
  logic [7:0] wdogQ, wdogD;
  logic       relayQ, relayD;
  logic       readyQ;
  logic       mismatch, expired, runNow, runNext;

  assign mismatch = cmp_valid & ~cmp_match;
  assign expired  = ~cmp_valid & (wdogQ == WDOG_LAST);
  assign runNow   = (stateQ == ST_RUN);
  assign runNext  = (stateD == ST_RUN);

  always_comb begin
    stateD = stateQ;
    faultD = faultQ;
    matchD = matchQ;
    wdogD  = '0;
    if (stateQ == ST_ARM || stateQ == ST_RUN) begin
      if (!cmp_valid && wdogQ != 8'hFF)
        wdogD = wdogQ + 8'd1;
      else if (!cmp_valid)
        wdogD = wdogQ;
    end
    unique case (stateQ)
      ST_IDLE: begin
        if (enable_req) begin
          stateD = ST_ARM;
          matchD = '0;
          wdogD  = '0;
        end
      end
      ST_ARM, ST_RUN: begin
        if (mismatch) begin
          stateD = ST_FAULT;
          faultD = FLT_MISMATCH;
        end else if (expired) begin
          stateD = ST_FAULT;
          faultD = FLT_TIMEOUT;
        end else if (!enable_req) begin
          stateD = ST_IDLE;
        end else if (stateQ == ST_ARM && cmp_valid) begin
          if (matchQ == ARM_LAST) begin
            stateD = ST_RUN;
            matchD = '0;
          end else begin
            matchD = matchQ + 4'd1;
          end
        end
      end
      ST_FAULT: begin
        if (fault_clear && !enable_req) begin
          stateD = ST_IDLE;
          faultD = FLT_NONE;
        end
      end
      default: stateD = ST_IDLE;
    endcase
  end

  // Relay starts opposite its idle level on the first RUN cycle.
  always_comb begin
    relayD = POLARITY;
    if (runNext)
      relayD = runNow ? ~relayQ : ~POLARITY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= ST_IDLE;
      faultQ <= FLT_NONE;
      matchQ <= '0;
      wdogQ  <= '0;
      relayQ <= POLARITY;
      readyQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      faultQ <= faultD;
      matchQ <= matchD;
      wdogQ  <= wdogD;
      relayQ <= relayD;
      readyQ <= runNext;
    end
  end

  pulse_phase_gen #(
    .POLARITY  (POLARITY),
    .SHORT_LEN (SHORT_LEN),
    .LONG_LEN  (LONG_LEN)
  ) uPulse (
    .clk        (clk),
    .rst        (rst),
    .runNow     (runNow),
    .runNext    (runNext),
    .switchCtrl (switch_ctrl)
  );

  assign relay_ctrl = relayQ;
  assign ready      = readyQ;
  assign state      = stateQ;
  assign fault_code = faultQ;

endmodule

// File: tb/tb_output_drive_sequencer.sv
// Scoreboard bench: channel A/B pair on shared stimulus, expected
// responses queued by the driver and checked by an independent monitor.
module tb_output_drive_sequencer;
  import output_seq_pkg::*;

  typedef struct {
    logic [1:0] st;
    logic [1:0] fc;
    logic       relA;
    logic       swA;
    logic       relB;
    logic       swB;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enReq = 1'b0;
  logic cmpValid = 1'b0;
  logic cmpMatch = 1'b0;
  logic faultClr = 1'b0;

  logic       relA, swA, rdyA;
  logic [1:0] stA, fcA;
  logic       relB, swB, rdyB;
  logic [1:0] stB, fcB;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   runIdx = 0;

  always #5 clk = ~clk;

  output_drive_sequencer #(.POLARITY(1'b0)) uA (
    .clk         (clk),
    .rst         (rst),
    .enable_req  (enReq),
    .cmp_valid   (cmpValid),
    .cmp_match   (cmpMatch),
    .fault_clear (faultClr),
    .relay_ctrl  (relA),
    .switch_ctrl (swA),
    .ready       (rdyA),
    .state       (stA),
    .fault_code  (fcA)
  );

  output_drive_sequencer #(.POLARITY(1'b1)) uB (
    .clk         (clk),
    .rst         (rst),
    .enable_req  (enReq),
    .cmp_valid   (cmpValid),
    .cmp_match   (cmpMatch),
    .fault_clear (faultClr),
    .relay_ctrl  (relB),
    .switch_ctrl (swB),
    .ready       (rdyB),
    .state       (stB),
    .fault_code  (fcB)
  );

  task automatic chk(input string nm, input logic [1:0] got,
                     input logic [1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got %0d exp %0d", nm, $time, got, want);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic cyc(input logic r, input logic en, input logic v,
                     input logic m, input logic clr,
                     input logic [1:0] est, input logic [1:0] efc,
                     input bit push);
    exp_t e;
    @(negedge clk);
    rst = r;
    enReq = en;
    cmpValid = v;
    cmpMatch = m;
    faultClr = clr;
    if (push) begin
      e.st = est;
      e.fc = efc;
      if (est == ST_RUN) begin
        e.relA = ((runIdx % 2) == 0);
        e.swA  = ((runIdx % 16) < 1);
        e.swB  = ((runIdx % 16) < 15);
        runIdx++;
      end else begin
        runIdx = 0;
        e.relA = 1'b0;
        e.swA  = 1'b0;
        e.swB  = 1'b0;
      end
      e.relB = ~e.relA;
      q.push_back(e);
    end
  endtask

  task automatic arm();
    cyc(0, 1, 0, 0, 0, ST_ARM, FLT_NONE, 1);
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 1, 0, ST_ARM, FLT_NONE, 1);
    cyc(0, 1, 1, 1, 0, ST_RUN, FLT_NONE, 1);
  endtask

  task automatic runFor(input int n, input logic v);
    for (int i = 0; i < n; i++)
      cyc(0, 1, v, 1, 0, ST_RUN, FLT_NONE, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stateA", stA, e.st);
        chk("stateB", stB, e.st);
        chk("faultA", fcA, e.fc);
        chk("faultB", fcB, e.fc);
        chk("readyA", {1'b0, rdyA}, {1'b0, e.st == ST_RUN});
        chk("readyB", {1'b0, rdyB}, {1'b0, e.st == ST_RUN});
        chk("relayA", {1'b0, relA}, {1'b0, e.relA});
        chk("relayB", {1'b0, relB}, {1'b0, e.relB});
        chk("switchA", {1'b0, swA}, {1'b0, e.swA});
        chk("switchB", {1'b0, swB}, {1'b0, e.swB});
        if (e.st == ST_RUN)
          chk("relayXor", {1'b0, relA ^ relB}, 2'd1);
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 5; i++)
      cyc(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          ST_IDLE, FLT_NONE, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 0, 0, 0, ST_IDLE, FLT_NONE, 1);

    arm();
    runFor(40, 1'b1);

    cyc(0, 1, 1, 0, 0, ST_FAULT, FLT_MISMATCH, 1);
    cyc(0, 1, 1, 1, 1, ST_FAULT, FLT_MISMATCH, 1);
    cyc(0, 1, 0, 0, 1, ST_FAULT, FLT_MISMATCH, 1);
    cyc(0, 0, 0, 0, 1, ST_IDLE, FLT_NONE, 1);

    arm();
    runFor(63, 1'b0);
    runFor(1, 1'b1);
    runFor(63, 1'b0);
    cyc(0, 1, 0, 0, 0, ST_FAULT, FLT_TIMEOUT, 1);
    cyc(0, 0, 1, 0, 0, ST_FAULT, FLT_TIMEOUT, 1);
    cyc(0, 0, 0, 0, 1, ST_IDLE, FLT_NONE, 1);

    arm();
    runFor(5, 1'b1);
    cyc(0, 0, 1, 0, 0, ST_FAULT, FLT_MISMATCH, 1);
    cyc(0, 0, 0, 0, 1, ST_IDLE, FLT_NONE, 1);

    arm();
    runFor(3, 1'b1);
    cyc(1, 1, 1, 1, 0, ST_IDLE, FLT_NONE, 1);
    cyc(0, 0, 0, 0, 0, ST_IDLE, FLT_NONE, 1);

    cyc(0, 1, 0, 0, 0, ST_ARM, FLT_NONE, 1);
    cyc(0, 0, 0, 0, 0, ST_IDLE, FLT_NONE, 1);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d exp 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
